lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, meaning the bus-wait cycle limit before an error completion (used only with LSU_TIMEOUT_EN).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports are listed as name, direction, width, meaning.
REQ-003 i_clk  in  1  system clock, rising-edge.
REQ-004 i_reset  in  1  asynchronous active-high reset.
REQ-005 i_mem_req  in  1  current instruction is a load or store.
REQ-006 i_mem_we  in  1  1 = store, 0 = load (MemRW).
REQ-007 i_load_type  in  4  0001 byte, 0011 half, 1111 word; any other value is treated as word.
REQ-008 i_load_signed  in  1  sign-extend load data.
REQ-009 i_addr  in  32  effective byte address (ALU result).
REQ-010 i_wdata  in  32  store data (rs2).
REQ-011 o_stall  out  1  freeze PC and register write.
REQ-012 o_done  out  1  single-cycle completion pulse.
REQ-013 o_rdata  out  32  aligned, extended load result.
REQ-014 o_misalign  out  1  completion was a misaligned-access fault.
REQ-015 o_bus_err  out  1  completion was a bus timeout.
REQ-016 o_bus_req / o_bus_we  out  1 / 1  bus request and write strobe.
REQ-017 o_bus_addr  out  32  word address, with bits [1:0] = 00.
REQ-018 o_bus_be / o_bus_wdata  out  4 / 32  byte enables and lane-shifted write data.
REQ-019 i_bus_gnt / i_bus_rvalid / i_bus_rdata  in  1 / 1 / 32  grant, read-valid, read data.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-021 IDLE: when i_mem_req=1, the block SHALL register addr, wdata, we, type and signed, then go to REQ. If the access is misaligned, it SHALL go to DONE with o_misalign=1 and issue no bus request.
REQ-022 Misaligned is defined as: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 REQ: o_bus_req=1 with address, we, be and wdata held stable until i_bus_gnt=1.
REQ-024 REQ: on gnt, a store SHALL go to DONE. A load SHALL go to WAIT, or directly to DONE if i_bus_rvalid=1 in the same cycle.
REQ-025 WAIT: on i_bus_rvalid=1, the block SHALL capture extracted data into o_rdata and go to DONE.
REQ-026 DONE: o_done=1 and o_stall=0 for exactly one cycle, then IDLE. i_mem_req SHALL be ignored in DONE.
REQ-027 o_stall SHALL equal (IDLE and i_mem_req) or REQ or WAIT. This path SHALL be combinational from i_mem_req.
REQ-028 Byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-029 Write data: byte replicated to all four lanes; half replicated to both halves.
REQ-030 Load extraction: shift rdata right by 8*addr[1:0], mask to size, then sign- or zero-extend per i_load_signed. Word loads are unaffected by signed.
REQ-031 o_rdata SHALL hold its last value except on a load capture. On misalign or timeout it SHALL be 0.
REQ-032 o_misalign and o_bus_err SHALL be valid only while o_done=1 and 0 otherwise.
REQ-033 A store SHALL never assert a load capture. rvalid seen outside REQ/WAIT SHALL be ignored.

Reset
REQ-034 On i_reset=1 the block SHALL go immediately to IDLE, asynchronously, even mid-transaction.
REQ-035 On reset, all outputs SHALL be 0: o_bus_req and o_done drop, o_rdata=0, timeout counter=0.
REQ-036 A grant or response arriving after reset SHALL be ignored.

Configuration
REQ-037 With LSU_TIMEOUT_EN defined, a counter SHALL run in REQ/WAIT and clear on leaving them.
REQ-038 With LSU_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL go to DONE with o_bus_err=1, o_bus_req=0 and o_rdata=0.
REQ-039 With LSU_TIMEOUT_EN undefined, there SHALL be no counter, the block SHALL wait indefinitely, and o_bus_err SHALL be tied to 0.

Structure
REQ-040 Shared package rv_pkg SHALL hold the lsu_state_e enum and the load-type constants LT_BYTE=0001, LT_HALF=0011, LT_WORD=1111.
REQ-041 One combinational sub-module, lsu_align, SHALL compute be, write-data shift, misalign and load extraction.

Verification
REQ-042 Bench SHALL cover SW at 0x100 with data 0xDEADBEEF and gnt 2 cycles late -> be=1111, addr=0x100, o_done 1 cycle after gnt, o_stall high 4 cycles.
REQ-043 Bench SHALL cover LB signed at 0x103 with rdata 0x80AABBCC -> be=1000, o_rdata=0xFFFFFF80.
REQ-044 Bench SHALL cover LHU at 0x102 with rdata 0x8001_1234 -> o_rdata=0x00008001; gnt and rvalid in the same cycle -> DONE next cycle.
REQ-045 Bench SHALL cover LW at 0x102 -> no o_bus_req; o_done=1 and o_misalign=1 on the cycle after the request.
REQ-046 Bench SHALL cover, with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, a load with no gnt -> o_bus_err=1 after 8 REQ cycles, o_rdata=0.
REQ-047 Bench SHALL cover i_reset asserted in WAIT -> o_bus_req/o_stall low the same cycle; a late rvalid is ignored.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared types and constants for the load/store unit:
//                FSM state enum, load-type codes and access-size decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Load/store unit controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Load-type codes as produced by the decoder
    localparam logic [3:0] LT_BYTE = 4'b0001;
    localparam logic [3:0] LT_HALF = 4'b0011;
    localparam logic [3:0] LT_WORD = 4'b1111;

    // Internal access-size classification
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Any load-type code that is not byte or half is treated as a word access
    function automatic lsu_size_e decode_size(input logic [3:0] load_type);
        lsu_size_e size;
        case (load_type)
            LT_BYTE: size = SZ_BYTE;
            LT_HALF: size = SZ_HALF;
            default: size = SZ_WORD;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational lane logic for the LSU: byte enables,
//                store-data lane replication, misalignment detection and
//                load-data extraction with sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_load_type,
    input  logic        i_load_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    lsu_size_e   w_size;
    logic [31:0] w_shifted;

    // Lane selection and extension, keyed on access size and byte offset
    always_comb begin
        w_size     = decode_size(i_load_type);
        w_shifted  = i_rdata >> {i_offset, 3'b000};
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        o_rdata    = w_shifted;
        case (w_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_load_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_be       = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_offset[0];
                o_rdata    = {{16{i_load_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_misalign = |i_offset;
                o_rdata    = w_shifted;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit controller. Accepts one load or store from
//                the core, performs it on a req/gnt/rvalid bus, stalls the
//                core meanwhile and signals completion with a one-cycle pulse.
//                Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [3:0]  i_load_type,
    input  logic        i_load_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("lsu_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_e  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_type;
    logic        r_signed;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_in_idle;
    logic [1:0]  w_sel_offset;
    logic [3:0]  w_sel_type;
    logic [3:0]  w_be;
    logic [31:0] w_lane_wdata;
    logic        w_misalign;
    logic [31:0] w_load_data;

    // In IDLE the lane logic looks at the incoming request so misalignment can
    // be decided before anything is issued; afterwards it uses the latched access
    always_comb begin
        w_in_idle    = (r_state == ST_IDLE);
        w_sel_offset = w_in_idle ? i_addr[1:0] : r_addr[1:0];
        w_sel_type   = w_in_idle ? i_load_type : r_type;
    end

    lsu_align u_align (
        .i_offset      (w_sel_offset),
        .i_load_type   (w_sel_type),
        .i_load_signed (r_signed),
        .i_wdata       (r_wdata),
        .i_rdata       (i_bus_rdata),
        .o_be          (w_be),
        .o_wdata       (w_lane_wdata),
        .o_misalign    (w_misalign),
        .o_rdata       (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_bus_err;
    logic               w_busy;
    logic               w_complete;
    logic               w_timeout;
    logic               w_leaving;

    // A bus completion takes priority over a timeout landing on the same cycle
    always_comb begin
        w_busy     = (r_state == ST_REQ) || (r_state == ST_WAIT);
        w_complete = ((r_state == ST_REQ) && i_bus_gnt && (r_we || i_bus_rvalid)) ||
                     ((r_state == ST_WAIT) && i_bus_rvalid);
        w_timeout  = w_busy && (r_cnt == C_CNT_LAST);
        w_leaving  = w_busy && (w_complete || w_timeout);
    end

    // Bus-wait counter: runs across REQ and WAIT, cleared whenever they are left
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_busy && !w_leaving) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign o_bus_err = 1'b0;
`endif

    // Transaction FSM with latched request and registered completion status
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_type     <= '0;
            r_signed   <= 1'b0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_bus_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_mem_req) begin
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_we     <= i_mem_we;
                        r_type   <= i_load_type;
                        r_signed <= i_load_signed;
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_bus_gnt && (r_we || i_bus_rvalid)) begin
                        if (!r_we) begin
                            r_rdata <= w_load_data;
                        end
                        r_state <= ST_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= ST_DONE;
                    end
`endif
                    else if (i_bus_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_bus_rvalid) begin
                        r_rdata <= w_load_data;
                        r_state <= ST_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= ST_DONE;
                    end
`endif
                end
                default: begin
                    r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                    r_bus_err  <= 1'b0;
`endif
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Core-side handshake; the stall must react to i_mem_req in the same cycle
    always_comb begin
        o_stall    = (w_in_idle && i_mem_req) ||
                     (r_state == ST_REQ) || (r_state == ST_WAIT);
        o_done     = (r_state == ST_DONE);
        o_misalign = r_misalign;
        o_rdata    = r_rdata;
    end

    // Bus-side request; all bus fields are zero when no request is outstanding
    always_comb begin
        o_bus_req   = (r_state == ST_REQ);
        o_bus_we    = o_bus_req && r_we;
        o_bus_addr  = o_bus_req ? {r_addr[31:2], 2'b00} : 32'd0;
        o_bus_be    = o_bus_req ? w_be : 4'd0;
        o_bus_wdata = o_bus_req ? w_lane_wdata : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl with directed scenarios and
//                randomized loads/stores against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import rv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_mem_req = 1'b0;
    logic        i_mem_we = 1'b0;
    logic [3:0]  i_load_type = 4'd0;
    logic        i_load_signed = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        o_stall, o_done, o_misalign, o_bus_err, o_bus_req, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt = 1'b0;
    logic        i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'd0;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_mem_req(i_mem_req), .i_mem_we(i_mem_we),
        .i_load_type(i_load_type), .i_load_signed(i_load_signed), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err), .o_bus_req(o_bus_req),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
        .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid),
        .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model (size/offset arithmetic) ----------------
    function automatic int size_bytes(input logic [3:0] lt);
        if (lt == 4'b0001) return 1;
        if (lt == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [3:0] lt, input logic [31:0] addr);
        return (addr % size_bytes(lt)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] lt, input logic [31:0] addr);
        int n = size_bytes(lt);
        int mask = (1 << n) - 1;
        int sh = mask << (addr % 4);
        return sh[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] lt, input logic [31:0] wd);
        int n = size_bytes(lt);
        longint unsigned lo = {32'd0, wd} % (64'd1 << (8 * n));
        longint unsigned rep = (n == 1) ? 64'h0101_0101 : (n == 2) ? 64'h0001_0001 : 64'd1;
        longint unsigned r = lo * rep;
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] lt, input bit sgn,
                                              input logic [31:0] addr, input logic [31:0] rd);
        int n = size_bytes(lt);
        longint unsigned m = 64'd1 << (8 * n);
        longint unsigned v = ({32'd0, rd} >> (8 * (addr % 4))) % m;
        if (sgn && n < 4 && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    // One complete access with a bus responder; gnt arrives on the (gnt_dly+1)th
    // request cycle, rvalid rv_dly cycles after the grant (0 = same cycle)
    task automatic run_txn(input bit we, input logic [3:0] lt, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                           input string name);
        bit exp_mis = model_misaligned(lt, addr);
        int exp_lat = exp_mis ? 1 : (we ? gnt_dly + 2 : gnt_dly + 2 + rv_dly);
        logic [31:0] exp_rd;
        int cyc = 0, stall_cnt = 0, req_cnt = 0, wait_cnt = 0;
        bit granted = 0, saw_req = 0, done_seen = 0;
        exp_rd = exp_mis ? 32'd0 : (we ? model_rdata : model_load(lt, sgn, addr, rd));

        i_mem_req = 1'b1; i_mem_we = we; i_load_type = lt; i_load_signed = sgn;
        i_addr = addr; i_wdata = wd;
        for (cyc = 0; cyc < 64; cyc++) begin
            i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
            #1;
            if (o_done) begin
                done_seen = 1;
                break;
            end
            if (o_stall) stall_cnt++;
            if (o_bus_req) begin
                saw_req = 1;
                req_cnt++;
                n_checks++;
                if (o_bus_addr !== {addr[31:2], 2'b00} || o_bus_be !== model_be(lt, addr) ||
                    o_bus_we !== we || (we && o_bus_wdata !== model_wdata(lt, wd))) begin
                    n_fail++;
                    $display("FAIL %s bus fields: addr=%h be=%b we=%b wdata=%h, want addr=%h be=%b we=%b wdata=%h",
                             name, o_bus_addr, o_bus_be, o_bus_we, o_bus_wdata,
                             {addr[31:2], 2'b00}, model_be(lt, addr), we, model_wdata(lt, wd));
                end
                if (req_cnt == gnt_dly + 1) begin
                    i_bus_gnt = 1'b1;
                    granted = 1;
                    if (we || rv_dly == 0) begin
                        i_bus_rvalid = 1'b1;   // for stores this rvalid must be ignored
                        i_bus_rdata = we ? $urandom : rd;
                    end
                end
            end else if (granted && !we) begin
                wait_cnt++;
                if (wait_cnt == rv_dly) begin
                    i_bus_rvalid = 1'b1;
                    i_bus_rdata = rd;
                end
            end
            @(posedge i_clk); #1;
        end
        i_mem_req = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        model_rdata = exp_rd;

        n_checks++;
        if (!done_seen || cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL %s done latency: done=%0d at cycle %0d, want cycle %0d", name, done_seen, cyc, exp_lat);
        end
        n_checks++;
        if (stall_cnt !== exp_lat || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall: %0d cycles (stall at done=%b), want %0d cycles and 0", name, stall_cnt, o_stall, exp_lat);
        end
        n_checks++;
        if (saw_req !== !exp_mis) begin
            n_fail++;
            $display("FAIL %s bus request seen=%b, want %b", name, saw_req, !exp_mis);
        end
        n_checks++;
        if (o_misalign !== exp_mis || o_bus_err !== 1'b0 || o_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s completion: mis=%b err=%b rdata=%h, want mis=%b err=0 rdata=%h",
                     name, o_misalign, o_bus_err, o_rdata, exp_mis, exp_rd);
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_done !== 1'b0 || o_misalign !== 1'b0 || o_rdata !== exp_rd || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: done=%b mis=%b stall=%b rdata=%h, want 0 0 0 %h",
                     name, o_done, o_misalign, o_stall, o_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #3;
        n_checks++;
        if (o_done !== 0 || o_stall !== 0 || o_bus_req !== 0 || o_rdata !== 0 ||
            o_misalign !== 0 || o_bus_err !== 0 || o_bus_be !== 0 || o_bus_addr !== 0) begin
            n_fail++;
            $display("FAIL reset outputs: done=%b stall=%b req=%b rdata=%h mis=%b err=%b be=%b addr=%h, want all 0",
                     o_done, o_stall, o_bus_req, o_rdata, o_misalign, o_bus_err, o_bus_be, o_bus_addr);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_rdata = 32'd0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_store_word();
        run_txn(1'b1, LT_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 2, 0, 32'd0, "sw_0x100");
    endtask

    task automatic test_load_byte_signed();
        run_txn(1'b0, LT_BYTE, 1'b1, 32'h103, 32'd0, 1, 2, 32'h80AA_BBCC, "lb_0x103");
    endtask

    task automatic test_load_half_same_cycle();
        run_txn(1'b0, LT_HALF, 1'b0, 32'h102, 32'd0, 0, 0, 32'h8001_1234, "lhu_0x102");
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, LT_WORD, 1'b0, 32'h102, 32'd0, 0, 0, 32'h1111_1111, "lw_mis_0x102");
        run_txn(1'b1, LT_HALF, 1'b0, 32'h205, 32'h1234_5678, 0, 0, 32'd0, "sh_mis_0x205");
    endtask

    task automatic test_random();
        logic [3:0] types [5] = '{4'b0001, 4'b0011, 4'b1111, 4'b0000, 4'b0110};
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = $urandom;
            // bias towards aligned addresses so most accesses reach the bus
            if ($urandom_range(0, 3) != 0) a[1:0] = (a[1:0] & {1'b1, ~a[2]}) & 2'b10;
            run_txn(1'($urandom_range(0, 1)), types[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                    a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, "random");
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        bit done_seen = 0;
        run_txn(1'b0, LT_WORD, 1'b0, 32'h300, 32'd0, 0, 1, 32'hCAFE_F00D, "lw_before_timeout");
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_load_type = LT_WORD; i_addr = 32'h400;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (o_done) begin
                done_seen = 1;
                break;
            end
            if (o_bus_req) req_cycles++;
            @(posedge i_clk); #1;
        end
        i_mem_req = 1'b0;
        model_rdata = 32'd0;
        n_checks++;
        if (!done_seen || req_cycles !== 8 || o_bus_err !== 1'b1 || o_bus_req !== 1'b0 || o_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout: done=%b req_cycles=%0d err=%b req=%b rdata=%h, want 1 8 1 0 00000000",
                     done_seen, req_cycles, o_bus_err, o_bus_req, o_rdata);
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_bus_err !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout err pulse: err=%b done=%b, want 0 0", o_bus_err, o_done);
        end
    endtask
`endif

    task automatic test_reset_in_wait();
        run_txn(1'b0, LT_WORD, 1'b0, 32'h500, 32'd0, 0, 1, 32'h1234_5678, "lw_prime");
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_load_type = LT_WORD; i_addr = 32'h40;
        @(posedge i_clk); #1;              // now in REQ
        i_bus_gnt = 1'b1;
        @(posedge i_clk); #1;              // now in WAIT
        i_bus_gnt = 1'b0;
        n_checks++;
        if (o_stall !== 1'b1 || o_bus_req !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wait state: stall=%b req=%b done=%b, want 1 0 0", o_stall, o_bus_req, o_done);
        end
        #2;
        i_reset = 1'b1; i_mem_req = 1'b0;
        #1;
        model_rdata = 32'd0;
        n_checks++;
        if (o_stall !== 1'b0 || o_bus_req !== 1'b0 || o_done !== 1'b0 || o_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async reset in wait: stall=%b req=%b done=%b rdata=%h, want 0 0 0 00000000",
                     o_stall, o_bus_req, o_done, o_rdata);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hA5A5_5A5A;
            @(posedge i_clk); #1;
            n_checks++;
            if (o_done !== 1'b0 || o_rdata !== 32'd0 || o_bus_req !== 1'b0 || o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL late response after reset: done=%b rdata=%h req=%b stall=%b, want 0 00000000 0 0",
                         o_done, o_rdata, o_bus_req, o_stall);
            end
        end
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_word();
        test_load_byte_signed();
        test_load_half_same_cycle();
        test_misaligned();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
